fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the RV32I decoder.
- Owns the PC and issues word-aligned requests to instruction memory.
- Buffers returned instructions in an in-order slot queue.
- Presents {pc, ir} to decode with a valid/ready handshake.
- Handles redirects from execute (branches, JAL/JALR) by flushing and discarding stale responses, and stops fetching on halt.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_queue.sv | 72 +++++++
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Also carries the bench-visible reset PC and canonical NOP encoding.
package fetch_unit_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] INSN_NOP         = 32'h0000_0013;
   localparam int          DEPTH_DEFAULT    = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
      logic        filled;
   } slot_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order slot queue: allocate at request, fill at response,
// pop at decode handshake, flush on redirect.
module fetch_queue
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     alloc,
   input  logic [31:0]              alloc_pc,
   input  logic                     fill,
   input  logic [31:0]              fill_ir,
   input  logic                     pop,
   output logic                     head_filled,
   output logic [31:0]              head_pc,
   output logic [31:0]              head_ir,
   output logic [$clog2(DEPTH):0]   count,
   output logic [$clog2(DEPTH):0]   pend
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   slot_t         slots [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW-1:0] fill_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
         head     <= '0;
         tail     <= '0;
         fill_ptr <= '0;
         count    <= '0;
         pend     <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
         head     <= '0;
         tail     <= '0;
         fill_ptr <= '0;
         count    <= '0;
         pend     <= '0;
      end else begin
         // alloc, fill and pop always target distinct slots
         if (alloc) begin
            slots[tail].pc     <= alloc_pc;
            slots[tail].ir     <= '0;
            slots[tail].filled <= 1'b0;
            tail               <= tail + 1'b1;
         end
         if (fill) begin
            slots[fill_ptr].ir     <= fill_ir;
            slots[fill_ptr].filled <= 1'b1;
            fill_ptr               <= fill_ptr + 1'b1;
         end
         if (pop) begin
            slots[head].filled <= 1'b0;
            head               <= head + 1'b1;
         end
         count <= count + CW'(alloc) - CW'(pop);
         pend  <= pend + CW'(alloc) - CW'(fill);
      end
   end

   assign head_filled = slots[head].filled;
   assign head_pc     = slots[head].pc;
   assign head_ir     = slots[head].ir;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, issues imem requests, tracks stale
// responses across redirects and feeds decode through fetch_queue.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = DEPTH_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_ir,
   input  logic        id_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   // drops can pile up across back-to-back redirects
   localparam int DW = AW + 4;

   logic [31:0]   pc;
   logic [DW-1:0] drop_cnt;
   logic [DW-1:0] drop_d;
   logic          halted;
   logic          head_filled;
   logic [CW-1:0] count;
   logic [CW-1:0] pend;
   logic          fill;
   logic          pop;

   assign imem_req  = rst_n && !halted && !redirect_valid
                      && (count < CW'(DEPTH));
   assign imem_addr = pc;
   assign if_valid  = head_filled && !redirect_valid;
   assign pop       = if_valid && id_ready;
   assign fill      = imem_rvalid && (drop_cnt == '0)
                      && !redirect_valid;

   always_comb begin
      drop_d = drop_cnt;
      if (redirect_valid)
         drop_d = drop_cnt + DW'(pend) - DW'(imem_rvalid);
      else if (imem_rvalid && (drop_cnt != '0))
         drop_d = drop_cnt - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         drop_cnt <= '0;
         halted   <= 1'b0;
      end else begin
         drop_cnt <= drop_d;
         if (halt) halted <= 1'b1;
         if (redirect_valid) pc <= word_align(redirect_pc);
         else if (imem_req)  pc <= pc + 32'd4;
      end
   end

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (redirect_valid),
      .alloc       (imem_req),
      .alloc_pc    (pc),
      .fill        (fill),
      .fill_ir     (imem_rdata),
      .pop         (pop),
      .head_filled (head_filled),
      .head_pc     (if_pc),
      .head_ir     (if_ir),
      .count       (count),
      .pend        (pend)
   );

   proto_chk: assert property (@(posedge clk) disable iff (!rst_n)
      !(imem_rvalid && (drop_cnt == '0) && (pend == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1- or 3-cycle imem model
// returning addr + NOP encoding as the instruction word.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_ir;
   logic        id_ready;

   int checks = 0;
   int errors = 0;
   int lat;
   int n;

   logic        p1, p2, p3;
   logic [31:0] a1, a2, a3;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RESET_PC_DEFAULT), .DEPTH(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_ir          (if_ir),
      .id_ready       (id_ready)
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1 <= 1'b0; p2 <= 1'b0; p3 <= 1'b0;
         a1 <= '0;   a2 <= '0;   a3 <= '0;
      end else begin
         p1 <= imem_req; a1 <= imem_addr;
         p2 <= p1;       a2 <= a1;
         p3 <= p2;       a3 <= a2;
      end
   end

   assign imem_rvalid = (lat == 1) ? p1 : p3;
   assign imem_rdata  = ((lat == 1) ? a1 : a3) + INSN_NOP;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic restart(input int l, input logic rdy);
      rst_n = 1'b0;
      lat = l;
      id_ready = rdy;
      redirect_valid = 1'b0;
      halt = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      lat = 1;
      id_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      halt = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_pc", if_pc, 32'd0);
      chk("rst_ir", if_ir, 32'd0);

      // 1: streaming with 1-cycle memory
      rst_n = 1'b1;
      #1;
      chk("t1_req0", 32'(imem_req), 32'd1);
      chk("t1_addr0", imem_addr, 32'h0);
      step();
      chk("t1_valid_early", 32'(if_valid), 32'd0);
      chk("t1_addr1", imem_addr, 32'h4);
      step();
      for (int k = 0; k < 6; k++) begin
         chk("t1_valid", 32'(if_valid), 32'd1);
         chk("t1_pc", if_pc, 32'(4 * k));
         chk("t1_ir", if_ir, 32'(4 * k) + INSN_NOP);
         step();
      end

      // 2: backpressure fills the queue
      restart(1, 1'b0);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         if (imem_req) begin
            chk("t2_addr", imem_addr, 32'(4 * n));
            n++;
         end
         step();
      end
      chk("t2_nreq", 32'(n), 32'd4);
      chk("t2_req_full", 32'(imem_req), 32'd0);
      id_ready = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk("t2_valid", 32'(if_valid), 32'd1);
         chk("t2_pc", if_pc, 32'(4 * k));
         if (k == 1) begin
            chk("t2_req16", 32'(imem_req), 32'd1);
            chk("t2_addr16", imem_addr, 32'd16);
         end
         step();
      end

      // 3: redirect drops two stale responses
      restart(3, 1'b1);
      step();
      step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0103;
      #1;
      chk("t3_req_redir", 32'(imem_req), 32'd0);
      chk("t3_valid_redir", 32'(if_valid), 32'd0);
      step();
      redirect_valid = 1'b0;
      #1;
      chk("t3_req", 32'(imem_req), 32'd1);
      chk("t3_addr", imem_addr, 32'h100);
      step();
      chk("t3_addr_drop", imem_addr, 32'h104);
      for (int i = 0; i < 20 && !if_valid; i++) step();
      chk("t3_valid", 32'(if_valid), 32'd1);
      chk("t3_pc", if_pc, 32'h100);
      chk("t3_ir", if_ir, 32'h100 + INSN_NOP);

      // 4: redirect coincident with a response and id_ready
      restart(1, 1'b1);
      repeat (4) step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0200;
      #1;
      chk("t4_rvalid", 32'(imem_rvalid), 32'd1);
      chk("t4_valid_redir", 32'(if_valid), 32'd0);
      chk("t4_req_redir", 32'(imem_req), 32'd0);
      step();
      redirect_valid = 1'b0;
      #1;
      chk("t4_empty", 32'(if_valid), 32'd0);
      chk("t4_req", 32'(imem_req), 32'd1);
      chk("t4_addr", imem_addr, 32'h200);
      step();
      step();
      chk("t4_valid", 32'(if_valid), 32'd1);
      chk("t4_pc", if_pc, 32'h200);

      // 5: halt with two requests in flight
      restart(3, 1'b1);
      step();
      halt = 1'b1;
      step();
      halt = 1'b0;
      #1;
      n = 0;
      for (int i = 0; i < 15; i++) begin
         chk("t5_req_off", 32'(imem_req), 32'd0);
         if (if_valid) begin
            chk("t5_pc", if_pc, 32'(4 * n));
            n++;
         end
         step();
      end
      chk("t5_ndeliv", 32'(n), 32'd2);
      rst_n = 1'b0;
      lat = 1;
      #1;
      chk("t5_rst_req", 32'(imem_req), 32'd0);
      chk("t5_rst_valid", 32'(if_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("t5_restart_req", 32'(imem_req), 32'd1);
      chk("t5_restart_addr", imem_addr, RESET_PC_DEFAULT);

      // 6: pc wrap and queue pointer wrap
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFF;
      step();
      redirect_valid = 1'b0;
      #1;
      chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
      step();
      chk("t6_addr_wrap", imem_addr, 32'h0);
      for (int i = 0; i < 10 && !if_valid; i++) step();
      for (int k = 0; k < 6; k++) begin
         chk("t6_valid", 32'(if_valid), 32'd1);
         chk("t6_pc", if_pc, 32'hFFFF_FFFC + 32'(4 * k));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
